// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU datapath between NUM_REQ requesters.
// Optional build macro ALU_ARB_STATS_EN adds the stat_ops / stat_stall counters.
module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]            stat_ops,
  output logic [31:0]            stat_stall
`endif
);

  localparam int DATA_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  logic [1:0]               state;
  logic [GNT_W-1:0]         rr_ptr;
  logic [GNT_W-1:0]         grant_idx;

  logic [2*NUM_REQ-1:0]     vld_dbl;
  logic [NUM_REQ-1:0]       vld_rot;
  logic                     win_found;
  logic [GNT_W-1:0]         win_offs;
  logic [GNT_W:0]           win_sum;
  logic [GNT_W-1:0]         win_idx;
  logic [GNT_W-1:0]         next_ptr;
  logic                     req_hs;
  logic                     rsp_hs;

  logic [DATA_W-1:0]        sel_a;
  logic [DATA_W-1:0]        sel_b;
  logic [3:0]               sel_op;

  logic signed [DATA_W-1:0] a_p0;
  logic signed [DATA_W-1:0] b_p0;
  logic [3:0]               op_p0;

  logic [DATA_W-1:0]        alu_y_p1;
  logic                     op_ok_p1;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_SLTU, OP_XOR, OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [3:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      OP_AND:  alu_calc = a & b;
      OP_OR:   alu_calc = a | b;
      OP_ADD:  alu_calc = a + b;
      OP_SUB:  alu_calc = a - b;
      OP_SLT:  alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLTU: alu_calc = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      OP_XOR:  alu_calc = a ^ b;
      OP_SLL:  alu_calc = a << b[4:0];
      OP_SRL:  alu_calc = $unsigned(a) >> b[4:0];
      OP_SRA:  alu_calc = a >>> b[4:0];
      default: alu_calc = '0;
    endcase
  endfunction

  // Rotate the valid vector so rr_ptr sits at bit 0; the lowest set bit is the winner.
  assign vld_dbl = {req_valid, req_valid};
  assign vld_rot = NUM_REQ'(vld_dbl >> rr_ptr);

  always_comb begin
    win_found = 1'b0;
    win_offs  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        win_found = 1'b1;
        win_offs  = GNT_W'(k);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr} + {1'b0, win_offs};
    if (win_sum >= (GNT_W+1)'(NUM_REQ)) begin
      win_sum = win_sum - (GNT_W+1)'(NUM_REQ);
    end
    win_idx = win_sum[GNT_W-1:0];
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == GNT_W'(k)) begin
        sel_a  = req_a[DATA_W*k +: DATA_W];
        sel_b  = req_b[DATA_W*k +: DATA_W];
        sel_op = req_op[4*k +: 4];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[grant_idx] = 1'b1;
    end
  end

  assign req_hs   = (state == IDLE) && win_found;
  assign rsp_hs   = (state == RESP) && rsp_ready[grant_idx];
  assign busy     = (state != IDLE);
  assign next_ptr = (grant_idx == GNT_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Stage p0: operands captured at the request handshake
  always_ff @(posedge clk) begin
    if (req_hs) begin
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      op_p0 <= sel_op;
    end
  end

  // Stage p1: shared ALU evaluated from the latched operands during EXEC
  assign alu_y_p1 = alu_calc(op_p0, a_p0, b_p0);
  assign op_ok_p1 = op_legal(op_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            grant_idx <= win_idx;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (op_ok_p1) begin
            rsp_result <= alu_y_p1;
            rsp_zero   <= (alu_y_p1 == '0);
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else if (state == RESP) begin
      if (rsp_ready[grant_idx]) begin
        if (!rsp_err) begin
          stat_ops <= stat_ops + 32'd1;
        end
      end else begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
